rgb_led_scheduler: RTL and testbench

//   Sequencer for the board's two plain LEDs and the RGB0 tri-colour LED.

---
 rtl/board_pkg.sv | 26 ++
 rtl/button_debouncer.sv | 49 ++++
 rtl/rgb_led_scheduler.sv | 93 +++++++++
 tb/tb_rgb_led_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared encodings for the board sequencer: FSM states, colour range and the
// packed output bundle driven to the LED/RGB pins.
package board_pkg;

   localparam int NUM_BTN = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [2:0] COLOR_FIRST = 3'd1;
   localparam logic [2:0] COLOR_LAST  = 3'd7;

   typedef struct packed {
      logic [1:0] led;
      logic [2:0] rgb;
   } led_out_t;

   // Black (0) is skipped: the sequence wraps 7 -> 1.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      return (c == COLOR_LAST) ? COLOR_FIRST : c + 3'd1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser, debounce counter and a registered
// single-cycle pulse on each debounced 0->1 transition.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 240_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_synced;

   assign w_synced = r_sync[1];
   assign o_press  = r_press;

   // r_cnt holds the run length of samples that disagree with r_level;
   // a sample matching the current level breaks the run.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync    <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_btn};
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
         if (w_synced == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= w_synced;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Start/pause/stop sequencer stepping RGB0 through the seven non-black colours,
// with a shared PWM dimmer and registered LED/RGB outputs.
module rgb_led_scheduler
   import board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 240_000,
   parameter int STEP_CYCLES     = 6_000_000,
   parameter int PWM_WIDTH       = 8,
   parameter int DUTY            = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] BTN,
   output logic [1:0] LED,
   output logic       RGB0_Red,
   output logic       RGB0_Green,
   output logic       RGB0_Blue
);

   localparam int                   STEP_W    = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [PWM_WIDTH-1:0] DUTY_W    = PWM_WIDTH'(DUTY);

   logic [NUM_BTN-1:0]   w_press;
   state_t               r_state;
   logic [2:0]           r_color;
   logic [STEP_W-1:0]    r_step;
   logic [PWM_WIDTH-1:0] r_pwm_cnt;
   logic                 w_pwm_on;
   led_out_t             r_out;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .i_clk   (clk),
         .i_rst_n (reset_n),
         .i_btn   (BTN[gi]),
         .o_press (w_press[gi])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pwm_cnt <= '0;
      else          r_pwm_cnt <= r_pwm_cnt + 1'b1;
   end

   assign w_pwm_on = (r_pwm_cnt < DUTY_W);

   // Outputs are sampled from the pre-edge state, so they trail the FSM by one clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_color <= COLOR_FIRST;
         r_step  <= '0;
         r_out   <= '0;
      end else begin
         r_out.led <= {r_state == ST_PAUSE, r_state == ST_RUN};
         r_out.rgb <= (r_state != ST_IDLE && w_pwm_on) ? r_color : 3'b000;
         case (r_state)
            ST_IDLE: begin
               if (w_press[0]) begin
                  r_state <= ST_RUN;
                  r_step  <= '0;
               end
            end
            ST_RUN: begin
               if (w_press[0]) begin
                  r_state <= ST_IDLE;
               end else if (w_press[1]) begin
                  r_state <= ST_PAUSE;
               end else if (r_step == STEP_LAST) begin
                  r_step  <= '0;
                  r_color <= next_color(r_color);
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            ST_PAUSE: begin
               if (w_press[0])      r_state <= ST_IDLE;
               else if (w_press[1]) r_state <= ST_RUN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign LED        = r_out.led;
   assign RGB0_Red   = r_out.rgb[0];
   assign RGB0_Green = r_out.rgb[1];
   assign RGB0_Blue  = r_out.rgb[2];

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Cycle-timed scoreboard bench for rgb_led_scheduler: each scenario queues the
// expected {LED, RGB} for specific clock numbers and a monitor compares them.
module tb_rgb_led_scheduler;

   localparam int DEB  = 4;
   localparam int STEP = 10;
   localparam int PW   = 3;
   localparam int DUTY = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] BTN = 2'b11;
   logic [1:0] LED;
   logic       red, green, blue;

   always #5 clk = ~clk;

   rgb_led_scheduler #(
      .DEBOUNCE_CYCLES(DEB),
      .STEP_CYCLES    (STEP),
      .PWM_WIDTH      (PW),
      .DUTY           (DUTY)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .BTN        (BTN),
      .LED        (LED),
      .RGB0_Red   (red),
      .RGB0_Green (green),
      .RGB0_Blue  (blue)
   );

   // cyc == number of rising edges since reset release
   int cyc;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [4:0] val;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (reset_n) begin
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            if (sb[0].cyc < cyc) begin
               failures++;
               $display("FAIL sb_missed cyc=%0d got none want entry for cyc %0d", cyc, sb[0].cyc);
            end else if ({LED, blue, green, red} !== sb[0].val) begin
               failures++;
               $display("FAIL sb_out cyc=%0d got led=%b rgb=%b want led=%b rgb=%b",
                        cyc, LED, {blue, green, red}, sb[0].val[4:3], sb[0].val[2:0]);
            end
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // output at edge k uses pwm_cnt == (k-1) mod 2**PW
   function automatic logic [2:0] gate(input int k, input logic [2:0] c);
      return (((k - 1) % (1 << PW)) < DUTY) ? c : 3'b000;
   endfunction

   // colour after edge j, given RUN entered at edge r with colour idx0 and step count cnt0
   function automatic int color_at(input int j, input int r, input int idx0, input int cnt0);
      int adv;
      adv = (cnt0 + j - r) / STEP;
      return ((idx0 - 1 + adv) % 7) + 1;
   endfunction

   task automatic push(input int k, input logic [1:0] led, input logic [2:0] rgb);
      exp_t e;
      e.cyc = k;
      e.val = {led, rgb};
      sb.push_back(e);
   endtask

   task automatic push_idle(input int k0, input int k1);
      for (int k = k0; k <= k1; k++) push(k, 2'b00, 3'b000);
   endtask

   task automatic push_pause(input int k0, input int k1, input int f);
      for (int k = k0; k <= k1; k++) push(k, 2'b10, gate(k, 3'(f)));
   endtask

   task automatic push_run(input int k0, input int k1, input int r, input int idx0, input int cnt0);
      for (int k = k0; k <= k1; k++) push(k, 2'b01, gate(k, 3'(color_at(k - 1, r, idx0, cnt0))));
   endtask

   task automatic press(input int b);
      BTN[b] = 1'b1;
      repeat (6) tick;
      BTN[b] = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      int n = 0;
      while (cyc < t && n < 1000) begin
         tick;
         n++;
      end
   endtask

   task automatic drain;
      int n = 0;
      while (sb.size() > 0 && n < 500) begin
         tick;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
         sb.delete();
      end
   endtask

   int run_r, q_r, f_r, r2_r, k_r;

   task automatic test_reset;
      repeat (3) tick;
      checks++;
      if (LED !== 2'b00) begin
         failures++;
         $display("FAIL reset_led got %b want 00", LED);
      end
      checks++;
      if ({blue, green, red} !== 3'b000) begin
         failures++;
         $display("FAIL reset_rgb got %b want 000", {blue, green, red});
      end
      BTN = 2'b00;
      reset_n = 1'b1;
      push_idle(1, 12);
      drain;
   endtask

   task automatic test_bounce;
      int c;
      c = cyc;
      push_idle(c + 1, c + 20);
      BTN[0] = 1'b1; tick;
      BTN[0] = 1'b0; tick;
      BTN[0] = 1'b1; tick;
      BTN[0] = 1'b0; tick;
      BTN[0] = 1'b1; tick; tick; tick;
      BTN[0] = 1'b0;
      drain;
   endtask

   task automatic test_start;
      int c;
      c = cyc;
      run_r = c + 8;
      push_idle(c + 1, c + 8);
      push_run(c + 9, c + 24, run_r, 1, 0);
      press(0);
      drain;
   endtask

   task automatic test_stepping;
      push_run(cyc + 1, run_r + 80, run_r, 1, 0);
      drain;
   endtask

   task automatic test_pause;
      int c, p;
      c = cyc + 1;
      while ((c - run_r) % STEP != 9) c++;
      p = c + 8;
      f_r = color_at(p - 1, run_r, 1, 0);
      q_r = p + 50;
      push_run(cyc + 1, p, run_r, 1, 0);
      push_pause(p + 1, q_r, f_r);
      push_run(q_r + 1, q_r + 20, q_r, f_r, 6);
      wait_cyc(c);
      press(1);
      wait_cyc(q_r - 8);
      press(1);
      drain;
   endtask

   task automatic test_priority;
      int c, c2;
      c = cyc + 1;
      while ((6 + c + 7 - q_r) % STEP == 9) c++;
      k_r = color_at(c + 7, q_r, f_r, 6);
      c2 = c + 14;
      r2_r = c2 + 8;
      push_run(cyc + 1, c + 8, q_r, f_r, 6);
      push_idle(c + 9, c2 + 8);
      push_run(c2 + 9, c2 + 30, r2_r, k_r, 0);
      wait_cyc(c);
      BTN = 2'b11;
      repeat (6) tick;
      BTN = 2'b00;
      wait_cyc(c2);
      press(0);
      drain;
   endtask

   task automatic test_mid_reset;
      int c, f2;
      c = cyc + 1;
      while ((c + 7 - r2_r) % STEP == 9) c++;
      f2 = color_at(c + 7, r2_r, k_r, 0);
      push_run(cyc + 1, c + 8, r2_r, k_r, 0);
      push_pause(c + 9, c + 14, f2);
      wait_cyc(c);
      press(1);
      drain;
      checks++;
      if (LED !== 2'b10) begin
         failures++;
         $display("FAIL pause_before_reset got led=%b want 10", LED);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({LED, blue, green, red} !== 5'b00000) begin
         failures++;
         $display("FAIL async_reset got led=%b rgb=%b want 00 000", LED, {blue, green, red});
      end
      tick; tick;
      reset_n = 1'b1;
      tick; tick;
      c = cyc;
      push_idle(c + 1, c + 8);
      push_run(c + 9, c + 30, c + 8, 1, 0);
      press(0);
      drain;
   endtask

   initial begin
      test_reset;
      test_bounce;
      test_start;
      test_stepping;
      test_pause;
      test_priority;
      test_mid_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
